// File: rtl/instr_fetch_queue_if.sv
// Instruction fetch queue bus: fetch-group input side, decode-group output
// side and the occupancy readout, bundled for the queue and its neighbours.
// The master view belongs to the loader/decoder side and the slave view to
// the queue itself.
interface instr_fetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int WAYS  = 2,
    parameter int DEPTH = 8
);
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WAYS-1:0]            in_valid;
    logic [WAYS-1:0][XLEN-1:0]  in_address;
    logic [WAYS-1:0][31:0]      in_instr;
    logic                       in_ready;

    logic [WAYS-1:0]            out_valid;
    logic [WAYS-1:0][XLEN-1:0]  out_address;
    logic [WAYS-1:0][31:0]      out_instr;
    logic                       out_ready;

    logic [OCC_W-1:0]           occupancy;

    modport master (
        output in_valid, in_address, in_instr, out_ready,
        input  in_ready, out_valid, out_address, out_instr, occupancy
    );

    modport slave (
        input  in_valid, in_address, in_instr, out_ready,
        output in_ready, out_valid, out_address, out_instr, occupancy
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// N-way instruction fetch queue between the loader and the decoders.
// Sparse fetch lanes are compacted into a circular buffer and the oldest
// WAYS entries are presented to the decoders in program order.
// Optional build macro INSTR_FETCH_QUEUE_BYPASS_EN: when the queue is empty
// the compacted fetch group is shown on the outputs in the same cycle and,
// if taken, never written into storage.
// The reset port is asynchronous and active-low.
module instr_fetch_queue #(
    parameter int XLEN  = 32,
    parameter int WAYS  = 2,
    parameter int DEPTH = 8
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    instr_fetch_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;

    logic [XLEN-1:0] mem_address [DEPTH];
    logic [31:0]     mem_instr   [DEPTH];

    logic [CNT_W-1:0]          offs [WAYS];
    logic [CNT_W-1:0]          in_count;
    logic [WAYS-1:0]           comp_valid;
    logic [WAYS-1:0][XLEN-1:0] comp_address;
    logic [WAYS-1:0][31:0]     comp_instr;

    logic             space_ok;
    logic             bypass;
    logic             write_en;
    logic [CNT_W-1:0] enq_count;
    logic [CNT_W-1:0] deq_count;

    // Room for a whole group is judged from the registered count only, so a
    // dequeue in the same cycle never lends space to the loader.
    assign space_ok     = (count <= CNT_W'(DEPTH - WAYS));
    assign bus.in_ready = reset & space_ok;

`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
    assign bypass = (count == '0) && !flush && space_ok;
`else
    assign bypass = 1'b0;
`endif

    // Destination slot of each fetch lane: the number of valid lanes below it.
    always_comb begin
        in_count = '0;
        for (int i = 0; i < WAYS; i++) begin
            offs[i]  = in_count;
            in_count = in_count + CNT_W'(bus.in_valid[i]);
        end
    end

    // Squeeze the sparse fetch lanes into a dense group, lowest lane first.
    always_comb begin
        comp_valid   = '0;
        comp_address = '0;
        comp_instr   = '0;
        for (int j = 0; j < WAYS; j++) begin
            comp_valid[j] = (CNT_W'(j) < in_count);
            for (int i = 0; i < WAYS; i++) begin
                if (bus.in_valid[i] && (offs[i] == CNT_W'(j))) begin
                    comp_address[j] = bus.in_address[i];
                    comp_instr[j]   = bus.in_instr[i];
                end
            end
        end
    end

    // Handshake bookkeeping: what is written and what is retired this cycle.
    always_comb begin
        write_en  = space_ok && (|bus.in_valid) && !flush && !(bypass && bus.out_ready);
        enq_count = write_en ? in_count : '0;
        deq_count = '0;
        if (bus.out_ready) begin
            deq_count = (count < CNT_W'(WAYS)) ? count : CNT_W'(WAYS);
        end
    end

    // Pointer and count registers; flush wins over any enqueue or dequeue.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_count);
            tail  <= tail + PTR_W'(enq_count);
            count <= count + enq_count - deq_count;
        end
    end

    // Storage write of the compacted group starting at tail, wrapping mod DEPTH.
    always_ff @(posedge clock) begin
        if (write_en) begin
            for (int j = 0; j < WAYS; j++) begin
                if (comp_valid[j]) begin
                    mem_address[tail + PTR_W'(j)] <= comp_address[j];
                    mem_instr[tail + PTR_W'(j)]   <= comp_instr[j];
                end
            end
        end
    end

    // Decoder view: oldest entries from head onwards, valid as a lane prefix.
    always_comb begin
        bus.out_valid   = '0;
        bus.out_address = '0;
        bus.out_instr   = '0;
        for (int i = 0; i < WAYS; i++) begin
            bus.out_valid[i]   = (CNT_W'(i) < count);
            bus.out_address[i] = mem_address[head + PTR_W'(i)];
            bus.out_instr[i]   = mem_instr[head + PTR_W'(i)];
        end
`ifdef INSTR_FETCH_QUEUE_BYPASS_EN
        if (bypass && reset) begin
            bus.out_valid   = comp_valid;
            bus.out_address = comp_address;
            bus.out_instr   = comp_instr;
        end
`endif
        bus.occupancy = count;
    end
endmodule
